vec_wb_assembler: RTL and testbench

Writeback assembler that sits between the data-memory load path and the register file write port. It accepts a destination register command, then collects element-serial load data (one element per handshake). It packs the elements into a full vector word and issues a single-cycle write on the register file's `regWrEnVec`/`regWrEnSc`/`regToWrite`/`dataIn` interface. It is the writer counterpart of the register file's write port: it produces exactly the signals the register file consumes.

---
 rtl/vec_wb_if.sv | 31 +++
 rtl/vec_wb_assembler.sv | 100 ++++++++++
 tb/tb_vec_wb_assembler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_wb_if.sv
// Bus between the load path (master side) and the writeback assembler (slave side).
// The register-file write signals travel on this bus as well.
interface vec_wb_if #(
  parameter int REG_SIZE = 8,
  parameter int VEC_SIZE = 4,
  parameter int SEL_BITS = 4
);
  logic                                cmd_valid;
  logic                                cmd_ready;
  logic [SEL_BITS-1:0]                 cmd_reg;
  logic                                elem_valid;
  logic                                elem_ready;
  logic [REG_SIZE-1:0]                 elem_data;
  logic                                flush;
  logic                                regWrEnSc;
  logic                                regWrEnVec;
  logic [SEL_BITS-1:0]                 regToWrite;
  logic [VEC_SIZE-1:0][REG_SIZE-1:0]   dataIn;
  logic                                busy;
  logic                                done;

  modport master (
    output cmd_valid, cmd_reg, elem_valid, elem_data, flush,
    input  cmd_ready, elem_ready, regWrEnSc, regWrEnVec, regToWrite, dataIn, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_reg, elem_valid, elem_data, flush,
    output cmd_ready, elem_ready, regWrEnSc, regWrEnVec, regToWrite, dataIn, busy, done
  );
endinterface

// File: rtl/vec_wb_assembler.sv
// Collects element-serial load data for one destination register and issues a
// single-cycle write on the register file write port.
module vec_wb_assembler #(
  parameter int REG_SIZE = 8,
  parameter int VEC_SIZE = 4,
  parameter int SEL_BITS = 4
) (
  input  logic     clk,
  input  logic     reset,
  vec_wb_if.slave  bus
);
  localparam int CNT_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
  localparam logic [SEL_BITS-1:0] NUM_VEC_REGS = SEL_BITS'(4);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] vec_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  vec_t                pack_q, pack_d;
  logic [SEL_BITS-1:0] reg_q, reg_d;
  logic                is_vec_q, is_vec_d;
  vec_t                hold_data_q, hold_data_d;
  logic [SEL_BITS-1:0] hold_reg_q, hold_reg_d;
  logic                last_elem;
  logic                in_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pack_q      <= '0;
      reg_q       <= '0;
      is_vec_q    <= 1'b0;
      hold_data_q <= '0;
      hold_reg_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pack_q      <= pack_d;
      reg_q       <= reg_d;
      is_vec_q    <= is_vec_d;
      hold_data_q <= hold_data_d;
      hold_reg_q  <= hold_reg_d;
    end
  end

  assign last_elem = is_vec_q ? (count_q == CNT_W'(VEC_SIZE - 1)) : (count_q == '0);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pack_d      = pack_q;
    reg_d       = reg_q;
    is_vec_d    = is_vec_q;
    hold_data_d = hold_data_q;
    hold_reg_d  = hold_reg_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          reg_d    = bus.cmd_reg;
          count_d  = '0;
          pack_d   = '0;
          is_vec_d = (bus.cmd_reg < NUM_VEC_REGS);
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        // Flush outranks a simultaneous element: nothing is consumed.
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.elem_valid) begin
          pack_d[count_q] = bus.elem_data;
          if (last_elem) begin
            state_d = WRITE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        // Snapshot so the write port keeps showing the last write afterwards.
        hold_data_d = pack_q;
        hold_reg_d  = reg_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_write       = (state_q == WRITE);
  assign bus.cmd_ready  = (state_q == IDLE) && reset;
  assign bus.elem_ready = (state_q == COLLECT) && !bus.flush;
  assign bus.regWrEnVec = in_write && is_vec_q;
  assign bus.regWrEnSc  = in_write && !is_vec_q;
  assign bus.done       = in_write;
  assign bus.busy       = (state_q != IDLE);
  assign bus.regToWrite = in_write ? reg_q  : hold_reg_q;
  assign bus.dataIn     = in_write ? pack_q : hold_data_q;
endmodule

// File: tb/tb_vec_wb_assembler.sv
// Self-checking bench for vec_wb_assembler: directed scenarios plus randomized
// commands checked against a packing model of the expected register write.
module tb_vec_wb_assembler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errs = 0;
  int   checks = 0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_reg = '0;

  vec_wb_if #(.REG_SIZE(8), .VEC_SIZE(4), .SEL_BITS(4)) bus ();

  vec_wb_assembler #(.REG_SIZE(8), .VEC_SIZE(4), .SEL_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one command and its elements; expected write is the elements packed
  // lane-by-lane (lane 0 lowest), 4 elements for regs 0..3, otherwise 1.
  task automatic run_cmd(input logic [3:0] r, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3,
                         input int bub_pct, input int lead, input bit flush_acc);
    logic [7:0]  el [4];
    logic [31:0] exp_data;
    bit          is_vec;
    bit          v;
    int          needed;
    int          got;
    int          cyc;
    el       = '{e0, e1, e2, e3};
    is_vec   = (r < 4);
    needed   = is_vec ? 4 : 1;
    got      = 0;
    cyc      = 0;
    exp_data = '0;

    bus.cmd_valid = 1'b1; bus.cmd_reg = r; bus.flush = flush_acc; bus.elem_valid = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      errs++; $display("FAIL accept_ready: got ready/busy=%b want 10", {bus.cmd_ready, bus.busy});
    end
    tick();
    bus.cmd_valid = 1'b0; bus.flush = 1'b0; bus.cmd_reg = 4'($urandom);

    while (got < needed && cyc < 64) begin
      cyc++;
      v = (cyc <= lead) ? 1'b0 : ($urandom_range(99) < bub_pct ? 1'b0 : 1'b1);
      bus.elem_valid = v;
      bus.elem_data  = v ? el[got] : 8'($urandom);
      #1;
      checks++;
      if ({bus.elem_ready, bus.busy, bus.cmd_ready, bus.regWrEnVec, bus.regWrEnSc, bus.done} !== 6'b110000) begin
        errs++;
        $display("FAIL collect_flags reg=%0d cyc=%0d: got rdy/busy/cmdrdy/vec/sc/done=%b want 110000",
                 r, cyc, {bus.elem_ready, bus.busy, bus.cmd_ready, bus.regWrEnVec, bus.regWrEnSc, bus.done});
      end
      if (v) begin
        exp_data = exp_data | (32'(el[got]) << (8 * got));
        got++;
      end
      tick();
    end
    checks++;
    if (got < needed) begin
      errs++; $display("FAIL collect_timeout reg=%0d: got %0d elems want %0d", r, got, needed);
    end

    // Write cycle: an extra element is offered and must not be taken.
    bus.elem_valid = 1'b1;
    bus.elem_data  = (got < 4) ? el[got] : 8'($urandom);
    #1;
    checks++;
    if ({bus.regWrEnVec, bus.regWrEnSc, bus.done, bus.elem_ready, bus.cmd_ready, bus.busy}
        !== {is_vec, !is_vec, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errs++;
      $display("FAIL write_flags reg=%0d: got vec/sc/done/rdy/cmdrdy/busy=%b want %b", r,
               {bus.regWrEnVec, bus.regWrEnSc, bus.done, bus.elem_ready, bus.cmd_ready, bus.busy},
               {is_vec, !is_vec, 1'b1, 1'b0, 1'b0, 1'b1});
    end
    checks++;
    if (bus.regToWrite !== r || bus.dataIn !== exp_data) begin
      errs++;
      $display("FAIL write_data reg=%0d: got addr=%0d data=%h want addr=%0d data=%h",
               r, bus.regToWrite, bus.dataIn, r, exp_data);
    end
    tick();
    bus.elem_valid = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.regWrEnVec, bus.regWrEnSc, bus.done} !== 5'b10000
        || bus.regToWrite !== r || bus.dataIn !== exp_data) begin
      errs++;
      $display("FAIL after_write reg=%0d: got flags=%b addr=%0d data=%h want flags=10000 addr=%0d data=%h",
               r, {bus.cmd_ready, bus.busy, bus.regWrEnVec, bus.regWrEnSc, bus.done},
               bus.regToWrite, bus.dataIn, r, exp_data);
    end
    last_data = exp_data;
    last_reg  = r;
    $display("cmd reg=%0d vec=%0d cycles=%0d data=%h", r, is_vec, cyc, exp_data);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if ({bus.cmd_ready, bus.elem_ready, bus.busy, bus.regWrEnVec, bus.regWrEnSc, bus.done} !== 6'b0
        || bus.regToWrite !== 4'd0 || bus.dataIn !== 32'd0) begin
      errs++; $display("FAIL reset_outputs: got flags=%b addr=%0d data=%h want all zero",
                       {bus.cmd_ready, bus.elem_ready, bus.busy, bus.regWrEnVec, bus.regWrEnSc, bus.done},
                       bus.regToWrite, bus.dataIn);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      errs++; $display("FAIL reset_release: got ready/busy=%b want 10", {bus.cmd_ready, bus.busy});
    end
    tick();
    $display("reset released");
  endtask

  task automatic test_vector();
    run_cmd(4'd3, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 0, 0, 1'b0);
    checks++;
    if (bus.dataIn !== 32'hDEADBEEF) begin
      errs++; $display("FAIL vector_const: got %h want DEADBEEF", bus.dataIn);
    end
  endtask

  task automatic test_scalar();
    run_cmd(4'd4, 8'h04, 8'h55, 8'h00, 8'h00, 0, 0, 1'b0);
    checks++;
    if (bus.dataIn !== 32'h00000004 || bus.regToWrite !== 4'd4) begin
      errs++; $display("FAIL scalar_const: got addr=%0d data=%h want 4 00000004", bus.regToWrite, bus.dataIn);
    end
  endtask

  task automatic test_special_bubbles();
    run_cmd(4'd13, 8'h07, 8'h99, 8'h00, 8'h00, 0, 3, 1'b0);
    checks++;
    if (bus.dataIn !== 32'h00000007 || bus.regToWrite !== 4'd13) begin
      errs++; $display("FAIL special_const: got addr=%0d data=%h want 13 00000007", bus.regToWrite, bus.dataIn);
    end
  endtask

  task automatic test_flush();
    bus.cmd_valid = 1'b1; bus.cmd_reg = 4'd2; tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.elem_valid = 1'b1; bus.elem_data = 8'hA1 + 8'(i);
      #1;
      checks++;
      if (bus.elem_ready !== 1'b1) begin
        errs++; $display("FAIL flush_pre_elem%0d: got ready=%b want 1", i, bus.elem_ready);
      end
      tick();
    end
    bus.flush = 1'b1; bus.elem_data = 8'hA3;
    #1;
    checks++;
    if ({bus.elem_ready, bus.regWrEnVec, bus.regWrEnSc, bus.done} !== 4'b0000) begin
      errs++; $display("FAIL flush_cycle: got rdy/vec/sc/done=%b want 0000",
                       {bus.elem_ready, bus.regWrEnVec, bus.regWrEnSc, bus.done});
    end
    tick();
    bus.flush = 1'b0; bus.elem_valid = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy, bus.regWrEnVec, bus.regWrEnSc, bus.done} !== 5'b10000
        || bus.dataIn !== last_data || bus.regToWrite !== last_reg) begin
      errs++; $display("FAIL flush_idle: got flags=%b addr=%0d data=%h want 10000 %0d %h",
                       {bus.cmd_ready, bus.busy, bus.regWrEnVec, bus.regWrEnSc, bus.done},
                       bus.regToWrite, bus.dataIn, last_reg, last_data);
    end
    $display("flush reg=2 after 2 elems");
    run_cmd(4'd0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 1'b0);
    checks++;
    if (bus.dataIn !== 32'h44332211) begin
      errs++; $display("FAIL flush_followup: got %h want 44332211", bus.dataIn);
    end
    // Flush in IDLE must not block a command accepted in the same cycle.
    run_cmd(4'd6, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 0, 1'b1);
  endtask

  task automatic test_reset_collect();
    bus.cmd_valid = 1'b1; bus.cmd_reg = 4'd1; tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.elem_valid = 1'b1; bus.elem_data = 8'($urandom); tick();
    end
    bus.elem_data = 8'hC4;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.elem_ready, bus.busy, bus.regWrEnVec, bus.regWrEnSc, bus.done} !== 6'b0
        || bus.regToWrite !== 4'd0 || bus.dataIn !== 32'd0) begin
      errs++; $display("FAIL midrun_reset: got flags=%b addr=%0d data=%h want all zero",
                       {bus.cmd_ready, bus.elem_ready, bus.busy, bus.regWrEnVec, bus.regWrEnSc, bus.done},
                       bus.regToWrite, bus.dataIn);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.regWrEnVec, bus.regWrEnSc, bus.done} !== 3'b000) begin
        errs++; $display("FAIL reset_no_write%0d: got vec/sc/done=%b want 000", i,
                         {bus.regWrEnVec, bus.regWrEnSc, bus.done});
      end
    end
    reset = 1'b1; bus.elem_valid = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.busy} !== 2'b10) begin
      errs++; $display("FAIL midrun_release: got ready/busy=%b want 10", {bus.cmd_ready, bus.busy});
    end
    last_data = '0; last_reg = '0;
    $display("reset during collect of reg=1");
    tick();
    run_cmd(4'd1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      run_cmd(4'($urandom_range(15)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(50), 0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      run_cmd(4'(n), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 1'b0);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_reg = '0; bus.elem_valid = 1'b0;
    bus.elem_data = '0; bus.flush = 1'b0;
    test_reset();
    test_vector();
    test_scalar();
    test_special_bubbles();
    test_flush();
    test_reset_collect();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
